// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, FIFO depth and FSM state encoding for the load/compute/store unit.
package lsu_pkg;
    localparam int FE_DATA_W  = 32;
    localparam int FE_ADDR_W  = 22;
    localparam int FIFO_DEPTH = 4;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/lsu_fifo.sv
// lsu_fifo: synchronous FIFO with flush; a push on a full FIFO is honoured when a pop happens in the same cycle.
module lsu_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rp];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/lsu_wrapper.sv
// lsu_wrapper: streams count words from load base, stores each word's unsigned byte sum to store base + index.
module lsu_wrapper #(
    parameter int DATA_WIDTH = lsu_pkg::FE_DATA_W,
    parameter int ADDR_WIDTH = lsu_pkg::FE_ADDR_W,
    parameter int FIFO_DEPTH = lsu_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] load_base_addr,
    input  logic [ADDR_WIDTH-1:0] store_base_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    output logic                  load_req,
    output logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_complete,
    output logic                  store_req,
    output logic [ADDR_WIDTH-1:0] store_addr,
    output logic [DATA_WIDTH-1:0] store_data,
    input  logic                  store_complete
);
    import lsu_pkg::*;
    state_e r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_load_base, r_store_base, r_count, r_load_idx, r_store_idx;
    logic [ADDR_WIDTH-1:0] r_load_addr, r_store_addr;
    logic [DATA_WIDTH-1:0] r_store_data, w_head;
    logic r_load_req, r_store_req;
    logic w_start, w_load_fire, w_store_fire, w_full, w_empty;
    logic [9:0] w_sum;
    assign w_start      = start && r_state != S_RUN;
    assign w_load_fire  = r_load_req && load_complete;
    assign w_store_fire = r_store_req && store_complete;
    assign w_sum = 10'(load_data[7:0]) + 10'(load_data[15:8]) + 10'(load_data[23:16]) + 10'(load_data[31:24]);
    assign done       = r_state == S_DONE;
    assign load_req   = r_load_req;
    assign load_addr  = r_load_addr;
    assign store_req  = r_store_req;
    assign store_addr = r_store_addr;
    assign store_data = r_store_data;
    lsu_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_start),
        .i_push  (w_load_fire),
        .i_data  (DATA_WIDTH'(w_sum)),
        .i_pop   (w_store_fire),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    // The run finishes on the edge that retires the last store.
    always_comb begin
        w_next = r_state;
        w_next = w_start ? (count == '0 ? S_DONE : S_RUN) :
                 (r_state == S_RUN && w_store_fire && r_store_idx + 1'b1 == r_count) ? S_DONE : r_state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_base  <= '0;
            r_store_base <= '0;
            r_count      <= '0;
            r_load_idx   <= '0;
            r_store_idx  <= '0;
            r_load_req   <= 1'b0;
            r_store_req  <= 1'b0;
            r_load_addr  <= '0;
            r_store_addr <= '0;
            r_store_data <= '0;
        end else if (w_start) begin
            r_load_base  <= load_base_addr;
            r_store_base <= store_base_addr;
            r_count      <= count;
            r_load_idx   <= '0;
            r_store_idx  <= '0;
            r_load_req   <= count != '0;
            r_load_addr  <= load_base_addr;
            r_store_req  <= 1'b0;
        end else if (r_state == S_RUN) begin
            // Requests drop for one cycle after each acknowledge before re-issuing.
            if (w_load_fire) begin
                r_load_req <= 1'b0;
                r_load_idx <= r_load_idx + 1'b1;
            end else if (!r_load_req && r_load_idx < r_count && !w_full) begin
                r_load_req  <= 1'b1;
                r_load_addr <= r_load_base + r_load_idx;
            end
            if (w_store_fire) begin
                r_store_req <= 1'b0;
                r_store_idx <= r_store_idx + 1'b1;
            end else if (!r_store_req && !w_empty) begin
                r_store_req  <= 1'b1;
                r_store_addr <= r_store_base + r_store_idx;
                r_store_data <= w_head;
            end
        end
    end
endmodule

// File: tb/tb_lsu_wrapper.sv
// tb_lsu_wrapper: scoreboard bench; expected load addresses and store words are queued at start and checked as the DUT issues them.
module tb_lsu_wrapper;
    logic clk = 0, reset = 0, start = 0, done;
    logic [21:0] load_base_addr = 0, store_base_addr = 0, count = 0;
    logic load_req, store_req, load_complete, store_complete;
    logic [21:0] load_addr, store_addr;
    logic [31:0] load_data, store_data;
    logic [31:0] mem [logic [21:0]];
    logic [21:0] ld_exp [$];
    logic [53:0] st_exp [$];
    int n_checks = 0, n_errors = 0;
    int load_lat = 0, store_lat = 0;
    int cyc = 0, last_st = 0, req_seen = 0, st_cnt = 0, occ = 0, max_occ = 0;

    lsu_wrapper dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .load_base_addr(load_base_addr), .store_base_addr(store_base_addr), .count(count),
        .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_complete(load_complete),
        .store_req(store_req), .store_addr(store_addr), .store_data(store_data), .store_complete(store_complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bsum(input logic [31:0] w);
        int s = 0;
        for (int b = 0; b < 4; b++) s += int'(w[8*b +: 8]);
        return 32'(s);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (load_req || store_req) req_seen++;
        if (load_req && load_complete) occ++;
        if (store_req && store_complete) begin
            occ--;
            st_cnt++;
            last_st = cyc;
        end
        if (!reset) occ = 0;
        if (occ > max_occ) max_occ = occ;
    end

    initial begin
        load_complete = 0;
        load_data = 0;
        forever begin
            @(negedge clk);
            load_complete = 0;
            if (load_req) begin
                repeat (load_lat) @(negedge clk);
                if (load_req) begin
                    if (ld_exp.size() == 0) chk("ld_extra", 32'(load_addr), 32'hFFFF_FFFF);
                    else chk("load_addr", 32'(load_addr), 32'(ld_exp.pop_front()));
                    load_data = mem.exists(load_addr) ? mem[load_addr] : 32'h0;
                    load_complete = 1;
                end
            end
        end
    end

    initial begin
        logic [53:0] e;
        store_complete = 0;
        forever begin
            @(negedge clk);
            store_complete = 0;
            if (store_req) begin
                repeat (store_lat) @(negedge clk);
                if (store_req) begin
                    if (st_exp.size() == 0) chk("st_extra", 32'(store_addr), 32'hFFFF_FFFF);
                    else begin
                        e = st_exp.pop_front();
                        chk("store_addr", 32'(store_addr), 32'(e[53:32]));
                        chk("store_data", store_data, e[31:0]);
                    end
                    mem[store_addr] = store_data;
                    store_complete = 1;
                end
            end
        end
    end

    task automatic push_exp(input logic [21:0] lb, input logic [21:0] sb, input logic [21:0] cn);
        logic [21:0] a, s;
        for (int i = 0; i < int'(cn); i++) begin
            a = lb + 22'(i);
            s = sb + 22'(i);
            ld_exp.push_back(a);
            st_exp.push_back({s, bsum(mem[a])});
        end
    endtask

    task automatic run(input logic [21:0] lb, input logic [21:0] sb, input logic [21:0] cn, input int sl, input bit mid);
        int r0, s0, t;
        store_lat = sl;
        push_exp(lb, sb, cn);
        @(negedge clk);
        r0 = req_seen;
        s0 = st_cnt;
        load_base_addr = lb;
        store_base_addr = sb;
        count = cn;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("first_req", 32'(load_req), 32'(cn != 0));
        chk("done_after_start", 32'(done), 32'(cn == 0));
        if (mid) begin
            repeat (3) @(negedge clk);
            load_base_addr = 22'h3FFFFE;
            store_base_addr = 22'h500;
            count = 2;
            start = 1;
            @(negedge clk);
            start = 0;
        end
        t = 0;
        while (!done && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done", 32'(done), 1);
        if (cn != 0) chk("done_lat", 32'(cyc), 32'(last_st));
        else chk("no_req", 32'(req_seen - r0), 0);
        chk("stores", 32'(st_cnt - s0), 32'(cn));
        chk("ld_left", 32'(ld_exp.size()), 0);
        chk("st_left", 32'(st_exp.size()), 0);
    endtask

    initial begin
        logic [31:0] basic [4] = '{32'h0102_0000, 32'h0101_0101, 32'hFFFF_FFFF, 32'h8080_8080};
        logic [31:0] basic_exp [4] = '{32'h003, 32'h004, 32'h3FC, 32'h200};
        logic [21:0] a;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_load_req", 32'(load_req), 0);
        chk("rst_store_req", 32'(store_req), 0);
        chk("rst_load_addr", 32'(load_addr), 0);
        chk("rst_store_addr", 32'(store_addr), 0);
        chk("rst_store_data", store_data, 0);
        reset = 1;
        for (int i = 0; i < 4; i++) mem[22'(i)] = basic[i];
        run(22'h0, 22'h10, 22'd4, 0, 0);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[22'h10 + 22'(i)], basic_exp[i]);
        run(22'h0, 22'h20, 22'd0, 0, 0);
        for (int i = 0; i < 8; i++) mem[22'h40 + 22'(i)] = $urandom;
        run(22'h40, 22'h100, 22'd8, 10, 0);
        chk("fifo_peak", 32'(max_occ), 4);
        for (int i = 0; i < 4; i++) begin
            a = 22'h3FFFFE + 22'(i);
            mem[a] = $urandom;
        end
        run(22'h3FFFFE, 22'h200, 22'd4, 0, 0);
        store_lat = 10;
        push_exp(22'h40, 22'h300, 22'd8);
        @(negedge clk);
        load_base_addr = 22'h40;
        store_base_addr = 22'h300;
        count = 8;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (12) @(negedge clk);
        reset = 0;
        #1;
        chk("abort_load_req", 32'(load_req), 0);
        chk("abort_store_req", 32'(store_req), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_load_addr", 32'(load_addr), 0);
        chk("abort_store_addr", 32'(store_addr), 0);
        chk("abort_store_data", store_data, 0);
        ld_exp.delete();
        st_exp.delete();
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (15) @(negedge clk);
        run(22'h40, 22'h300, 22'd8, 0, 0);
        run(22'h0, 22'h400, 22'd4, 2, 1);
        run(22'h40, 22'h600, 22'd3, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_wrapper.md
# lsu_wrapper

Streaming load/compute/store unit that sits between a host-programmed configuration interface and a simple word-addressed memory port. On `start` it reads `count` consecutive 32-bit words from `load_base_addr`, reduces each word to the unsigned sum of its four bytes, and writes each result to the matching word at `store_base_addr`. Loads and stores are decoupled by an internal FIFO so the load stream can run ahead of the store stream.

## Interface
- `DATA_WIDTH`, default `FE_DATA_W` (32): memory data width; the byte-sum datapath requires exactly 32.
- `ADDR_WIDTH`, default `FE_ADDR_W` (22): word address width; also the width of `count`.
- `FIFO_DEPTH`, default `FIFO_DEPTH` (4): number of entries in the load-to-store result FIFO; must be a power of two and at least 2.

Ports, each listed as name, direction, width, meaning:
- `clk`, in, 1: single clock; all logic is clocked on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: sampled high in IDLE or DONE, it latches the configuration and begins a run.
- `done`, out, 1: high when a run has completed.
- `load_base_addr`, in, ADDR_WIDTH: first word address to load.
- `store_base_addr`, in, ADDR_WIDTH: first word address to store.
- `count`, in, ADDR_WIDTH: number of words to process.
- `load_req`, out, 1: load request.
- `load_addr`, out, ADDR_WIDTH: load word address.
- `load_data`, in, DATA_WIDTH: load data; valid when `load_complete` is high.
- `load_complete`, in, 1: load acknowledge.
- `store_req`, out, 1: store request.
- `store_addr`, out, ADDR_WIDTH: store word address.
- `store_data`, out, DATA_WIDTH: store data.
- `store_complete`, in, 1: store acknowledge.

## Operation
- Top FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when stores issued equals latched count.
  - DONE → RUN on `start`.
- On `start`, latch `load_base_addr`, `store_base_addr` and `count`. Clear the load and store indices and the FIFO.
- `count` = 0: go straight to DONE, with no memory requests.
- `start` is ignored while in RUN. Configuration input changes during RUN have no effect.
- Load engine:
  - While the load index is below count and the FIFO is not full, assert `load_req` with `load_addr` = latched load base + load index.
  - On `load_complete`, compute `sum = b0+b1+b2+b3` as 10 bits unsigned (range 0..0x3FC). Push `{22'b0, sum}` into the FIFO and increment the load index.
- Store engine:
  - While the FIFO is not empty, assert `store_req` with `store_addr` = latched store base + store index and `store_data` = FIFO head.
  - On `store_complete`, pop the FIFO and increment the store index.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Results are stored in load order. Result i always goes to store base + i.
- `done` is high in DONE only. It holds until the next `start`, then drops the following cycle.

## Timing
- Reset values:
  - `done`, `load_req`, `store_req` = 0.
  - `load_addr`, `store_addr`, `store_data` = 0.
  - FSM in IDLE, FIFO empty.
- First `load_req` is asserted on the cycle after `start` is sampled.
- Request handshake (applies identically to load and store):
  - `req` is a level. Hold `req` and its address/data stable until `complete` is sampled high.
  - Deassert `req` in the cycle following that edge.
  - Keep `req` low for at least one cycle before the next request.
  - Each complete pulse retires exactly one transaction.
  - A `complete` pulse seen while `req` is low is ignored.
- Load and store transactions may be outstanding in the same cycle.
- A push and a pop in the same cycle on a full or empty-boundary FIFO are both honoured.
- Minimum of 2 cycles per word per engine.
- `done` rises on the cycle after the final `store_complete`.
- Asserting `reset` mid-run aborts immediately:
  - all requests drop;
  - the FIFO is flushed;
  - the FSM returns to IDLE.

## Structure
- Shared constants header supplies `FE_DATA_W`, `FE_ADDR_W`, and `FIFO_DEPTH`.
- One sub-module: `lsu_fifo`, a synchronous FIFO parameterised by width and depth, with push, pop, full, empty and flush.
- The byte-sum is combinational logic inside the wrapper.

## Test plan
- Basic run: memory[0..3] = 0x01020000, 0x01010101, 0xFFFFFFFF, 0x80808080; load base 0x0, store base 0x10, count 4. Required result: memory[0x10..0x13] = 0x003, 0x004, 0x3FC, 0x200, then `done` = 1.
- count = 0: `done` asserts with no `load_req` or `store_req`.
- Slow store acknowledge (`store_complete` delayed 10 cycles) with count 8: `load_req` stalls once the FIFO holds FIFO_DEPTH results; all 8 results are correct and in order.
- Address wrap: load base 0x3FFFFE, count 4. Required: load addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- `reset` asserted mid-run: outputs go to reset values. A fresh `start` then completes correctly.
- `start` pulsed during RUN is ignored. A second `start` from DONE reruns with the new configuration and clears `done`.
